pio_shift_unit: RTL

- Parametrised input/output shift-register engine for the PIO state machine: ISR and OSR of width W with shift counters, selectable shift direction, autopush/autopull thresholds and FIFO handshakes.
- Sits between the state-machine execute stage, which issues one op per enabled cycle, and the RX/TX FIFOs.
- Adds configurable width, threshold-driven autopush/autopull, blocking and conditional PUSH/PULL, and stall reporting.

---
 rtl/pio_shift_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pio_shift_unit.sv
// PIO input/output shift engine: ISR/OSR with shift counters, autopush/autopull
// thresholds and RX/TX FIFO handshakes. Every op either completes or stalls.
module pio_shift_unit #(
  parameter  int W  = 32,
  localparam int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [2:0]    op,
  input  logic [SW-1:0] count,
  input  logic          blk,
  input  logic          cond,
  input  logic [W-1:0]  in_data,
  input  logic [W-1:0]  x_in,
  input  logic          in_right,
  input  logic          out_right,
  input  logic          autopush,
  input  logic          autopull,
  input  logic [SW-1:0] push_thresh,
  input  logic [SW-1:0] pull_thresh,
  input  logic          rx_full,
  input  logic          tx_empty,
  input  logic [W-1:0]  tx_data,
  output logic          rx_push,
  output logic [W-1:0]  rx_data,
  output logic          rx_drop,
  output logic          tx_pull,
  output logic [W-1:0]  out_data,
  output logic [SW:0]   isr_cnt,
  output logic [SW:0]   osr_cnt,
  output logic          done,
  output logic          stall
);

  localparam logic [2:0] OP_IN   = 3'd1;
  localparam logic [2:0] OP_OUT  = 3'd2;
  localparam logic [2:0] OP_PUSH = 3'd3;
  localparam logic [2:0] OP_PULL = 3'd4;

  localparam logic [SW:0] W_CNT = (SW+1)'(W);

  logic [W-1:0]  isr_q, osr_q;
  logic [W-1:0]  isr_d, osr_d, out_data_d, rx_data_d;
  logic [SW:0]   isr_cnt_d, osr_cnt_d;
  logic          rx_push_d, rx_drop_d, tx_pull_d, done_d, stall_d;

  logic [SW:0]   n, push_lim, pull_lim;
  logic [W-1:0]  mask, in_bits, isr_shift;
  logic [SW+1:0] isr_sum, osr_sum;
  logic [SW:0]   isr_cnt_sat, osr_cnt_sat, osr_base_cnt;
  logic          reload;
  logic [W-1:0]  osr_src, osr_shift, out_word;

  // A zero in any count or threshold field stands for the full width W.
  assign n        = (count == '0)       ? W_CNT : {1'b0, count};
  assign push_lim = (push_thresh == '0) ? W_CNT : {1'b0, push_thresh};
  assign pull_lim = (pull_thresh == '0) ? W_CNT : {1'b0, pull_thresh};
  assign mask     = (n == W_CNT) ? '1 : ((W'(1) << n) - W'(1));

  assign in_bits     = in_data & mask;
  assign isr_shift   = in_right ? ((isr_q >> n) | (in_bits << (W_CNT - n)))
                                : ((isr_q << n) | in_bits);
  assign isr_sum     = {1'b0, isr_cnt} + {1'b0, n};
  assign isr_cnt_sat = (isr_sum > {1'b0, W_CNT}) ? W_CNT : isr_sum[SW:0];

  // An autopull refill feeds the fresh word straight into the same OUT shift.
  assign reload       = autopull && (osr_cnt >= pull_lim);
  assign osr_src      = reload ? tx_data : osr_q;
  assign osr_base_cnt = reload ? '0 : osr_cnt;
  assign out_word     = out_right ? (osr_src & mask) : (osr_src >> (W_CNT - n));
  assign osr_shift    = out_right ? (osr_src >> n) : (osr_src << n);
  assign osr_sum      = {1'b0, osr_base_cnt} + {1'b0, n};
  assign osr_cnt_sat  = (osr_sum > {1'b0, W_CNT}) ? W_CNT : osr_sum[SW:0];

  always_comb begin
    isr_d      = isr_q;
    isr_cnt_d  = isr_cnt;
    osr_d      = osr_q;
    osr_cnt_d  = osr_cnt;
    out_data_d = out_data;
    rx_data_d  = rx_data;
    rx_push_d  = 1'b0;
    rx_drop_d  = 1'b0;
    tx_pull_d  = 1'b0;
    done_d     = 1'b0;
    stall_d    = 1'b0;
    if (en) begin
      case (op)
        OP_IN: begin
          if (autopush && (isr_cnt_sat >= push_lim)) begin
            if (rx_full) begin
              stall_d = 1'b1;
            end else begin
              rx_push_d = 1'b1;
              rx_data_d = isr_shift;
              isr_d     = '0;
              isr_cnt_d = '0;
              done_d    = 1'b1;
            end
          end else begin
            isr_d     = isr_shift;
            isr_cnt_d = isr_cnt_sat;
            done_d    = 1'b1;
          end
        end
        OP_OUT: begin
          if (reload && tx_empty) begin
            stall_d = 1'b1;
          end else begin
            tx_pull_d  = reload;
            out_data_d = out_word;
            osr_d      = osr_shift;
            osr_cnt_d  = osr_cnt_sat;
            done_d     = 1'b1;
          end
        end
        OP_PUSH: begin
          if (cond && (isr_cnt < push_lim)) begin
            done_d = 1'b1;
          end else if (!rx_full) begin
            rx_push_d = 1'b1;
            rx_data_d = isr_q;
            isr_d     = '0;
            isr_cnt_d = '0;
            done_d    = 1'b1;
          end else if (blk) begin
            stall_d = 1'b1;
          end else begin
            rx_drop_d = 1'b1;
            isr_d     = '0;
            isr_cnt_d = '0;
            done_d    = 1'b1;
          end
        end
        OP_PULL: begin
          if (cond && (osr_cnt < pull_lim)) begin
            done_d = 1'b1;
          end else if (!tx_empty) begin
            tx_pull_d = 1'b1;
            osr_d     = tx_data;
            osr_cnt_d = '0;
            done_d    = 1'b1;
          end else if (blk) begin
            stall_d = 1'b1;
          end else begin
            osr_d     = x_in;
            osr_cnt_d = '0;
            done_d    = 1'b1;
          end
        end
        default: done_d = 1'b1;
      endcase
    end
  end

  // OSR powers up empty so the very first autopull refills it.
  always_ff @(posedge clk) begin
    if (reset) begin
      isr_q    <= '0;
      osr_q    <= '0;
      isr_cnt  <= '0;
      osr_cnt  <= W_CNT;
      out_data <= '0;
      rx_data  <= '0;
      rx_push  <= 1'b0;
      rx_drop  <= 1'b0;
      tx_pull  <= 1'b0;
      done     <= 1'b0;
      stall    <= 1'b0;
    end else begin
      isr_q    <= isr_d;
      osr_q    <= osr_d;
      isr_cnt  <= isr_cnt_d;
      osr_cnt  <= osr_cnt_d;
      out_data <= out_data_d;
      rx_data  <= rx_data_d;
      rx_push  <= rx_push_d;
      rx_drop  <= rx_drop_d;
      tx_pull  <= tx_pull_d;
      done     <= done_d;
      stall    <= stall_d;
    end
  end

endmodule
